// File: rtl/aes_axil_pkg.sv
// Shared register map, sequencer state encoding and error codes for the AES AXI4-Lite sequencer.
package aes_axil_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OFF_W   = 8;
    localparam int unsigned STATE_W = 4;

    localparam logic [OFF_W-1:0] OFF_CTRL    = 8'd0;
    localparam logic [OFF_W-1:0] OFF_CONFIG  = 8'd4;
    localparam logic [OFF_W-1:0] OFF_STATUS  = 8'd8;
    localparam logic [OFF_W-1:0] OFF_KEY0    = 8'd24;
    localparam logic [OFF_W-1:0] OFF_BLOCK0  = 8'd56;
    localparam logic [OFF_W-1:0] OFF_RESULT0 = 8'd72;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] ST_WR_KEY   = 4'd1;
    localparam logic [STATE_W-1:0] ST_WR_CFG   = 4'd2;
    localparam logic [STATE_W-1:0] ST_WR_INIT  = 4'd3;
    localparam logic [STATE_W-1:0] ST_WR_CLR   = 4'd4;
    localparam logic [STATE_W-1:0] ST_POLL_RDY = 4'd5;
    localparam logic [STATE_W-1:0] ST_WR_BLK   = 4'd6;
    localparam logic [STATE_W-1:0] ST_WR_NEXT  = 4'd7;
    localparam logic [STATE_W-1:0] ST_WR_CLR2  = 4'd8;
    localparam logic [STATE_W-1:0] ST_POLL_VLD = 4'd9;
    localparam logic [STATE_W-1:0] ST_RD_RES   = 4'd10;
    localparam logic [STATE_W-1:0] ST_FINISH   = 4'd11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BRESP   = 2'd1;
    localparam logic [1:0] ERR_RRESP   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef struct packed {
        logic              we;
        logic [OFF_W-1:0]  offset;
        logic [DATA_W-1:0] wdata;
    } axil_req_t;

    // Byte offset of word idx within a multi-word register bank.
    function automatic logic [OFF_W-1:0] word_offset(input logic [OFF_W-1:0] base,
                                                     input logic [2:0] idx);
        return base + {3'b000, idx, 2'b00};
    endfunction

endpackage

// File: rtl/axil_master_port.sv
// Single-transaction AXI4-Lite master engine: one write or one read per request.
module axil_master_port #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_WR   = 2'd1;
    localparam logic [1:0] PH_RD   = 2'd2;

    logic [1:0]            phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic [31:0]           wdata_d;
    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;
    assign axi_wstrb  = 4'hF;

    // Completion is seen the same cycle the response is accepted so the caller can advance at once.
    assign ack = (phase_q == PH_WR && axi_bvalid && axi_bready) ||
                 (phase_q == PH_RD && axi_rvalid && axi_rready);
    assign resp_err = ack && ((phase_q == PH_WR) ? (axi_bresp != 2'b00) : (axi_rresp != 2'b00));
    assign rdata = axi_rdata;

    always_comb begin
        phase_d   = phase_q;
        awaddr_d  = axi_awaddr;
        araddr_d  = axi_araddr;
        wdata_d   = axi_wdata;
        awvalid_d = axi_awvalid;
        wvalid_d  = axi_wvalid;
        bready_d  = axi_bready;
        arvalid_d = axi_arvalid;
        rready_d  = axi_rready;
        case (phase_q)
            PH_IDLE: begin
                if (req) begin
                    if (we) begin
                        awaddr_d  = addr;
                        wdata_d   = wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        phase_d   = PH_WR;
                    end else begin
                        araddr_d  = addr;
                        arvalid_d = 1'b1;
                        phase_d   = PH_RD;
                    end
                end
            end
            PH_WR: begin
                if (axi_awvalid && axi_awready) awvalid_d = 1'b0;
                if (axi_wvalid && axi_wready)   wvalid_d  = 1'b0;
                if (axi_bvalid && axi_bready) begin
                    bready_d = 1'b0;
                    phase_d  = PH_IDLE;
                end
            end
            PH_RD: begin
                if (axi_arvalid && axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (axi_rvalid && axi_rready) begin
                    rready_d = 1'b0;
                    phase_d  = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q     <= PH_IDLE;
            axi_awaddr  <= '0;
            axi_araddr  <= '0;
            axi_wdata   <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            axi_awaddr  <= awaddr_d;
            axi_araddr  <= araddr_d;
            axi_wdata   <= wdata_d;
            axi_awvalid <= awvalid_d;
            axi_wvalid  <= wvalid_d;
            axi_bready  <= bready_d;
            axi_arvalid <= arvalid_d;
            axi_rready  <= rready_d;
        end
    end

endmodule

// File: rtl/aes_axil_sequencer.sv
// Runs a full AES key/config/init/block/next/readback sequence on aes_v1_0 over AXI4-Lite.
module aes_axil_sequencer
    import aes_axil_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           POLL_LIMIT = 1024
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,
    input  logic                  start,
    input  logic                  reuse_key,
    input  logic [255:0]          key,
    input  logic                  key256,
    input  logic                  encdec,
    input  logic [127:0]          block_in,
    output logic [127:0]          result,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [2:0]            m00_axi_awprot,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    output logic [31:0]           m00_axi_wdata,
    output logic [3:0]            m00_axi_wstrb,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,
    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]            m00_axi_arprot,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [31:0]           m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         word_q, word_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic               busy_d, done_d, error_d;
    logic [1:0]         err_code_d;
    logic [127:0]       result_d;
    logic [255:0]       key_q, key_d;
    logic [127:0]       blk_q, blk_d;
    logic [1:0]         cfg_q, cfg_d;
    logic [255:0]       key_sh;
    logic [127:0]       blk_sh;
    logic               timeout_c;
    logic               port_req_c, port_ack, port_err;
    logic [31:0]        port_rdata;
    axil_req_t          preq;

    // Current word sits in the top 32 bits after shifting by the word index.
    assign key_sh = key_q << {word_q, 5'b00000};
    assign blk_sh = blk_q << {word_q[1:0], 5'b00000};

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        poll_d     = poll_q;
        busy_d     = busy_q_w();
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code;
        result_d   = result;
        key_d      = key_q;
        blk_d      = blk_q;
        cfg_d      = cfg_q;
        timeout_c  = 1'b0;
        port_req_c = 1'b0;
        preq       = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    err_code_d = ERR_NONE;
                    key_d      = key;
                    blk_d      = block_in;
                    cfg_d      = {key256, encdec};
                    word_d     = '0;
                    poll_d     = '0;
                    state_d    = reuse_key ? ST_WR_BLK : ST_WR_KEY;
                end
            end
            ST_WR_KEY: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = word_offset(OFF_KEY0, word_q);
                preq.wdata  = (word_q[2] && !cfg_q[1]) ? 32'h0 : key_sh[255:224];
                if (port_ack) begin
                    word_d = word_q + 3'd1;
                    if (word_q == 3'd7) state_d = ST_WR_CFG;
                end
            end
            ST_WR_CFG: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = OFF_CONFIG;
                preq.wdata  = {30'h0, cfg_q};
                if (port_ack) state_d = ST_WR_INIT;
            end
            ST_WR_INIT: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = OFF_CTRL;
                preq.wdata  = 32'h1;
                if (port_ack) state_d = ST_WR_CLR;
            end
            ST_WR_CLR: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = OFF_CTRL;
                if (port_ack) begin
                    state_d = ST_POLL_RDY;
                    poll_d  = '0;
                end
            end
            ST_POLL_RDY: begin
                port_req_c  = 1'b1;
                preq.offset = OFF_STATUS;
                if (port_ack) begin
                    if (port_rdata[0]) begin
                        state_d = ST_WR_BLK;
                        word_d  = '0;
                    end else if (poll_q + POLL_W'(1) == POLL_W'(POLL_LIMIT)) begin
                        timeout_c = 1'b1;
                    end else begin
                        poll_d = poll_q + POLL_W'(1);
                    end
                end
            end
            ST_WR_BLK: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = word_offset(OFF_BLOCK0, word_q);
                preq.wdata  = blk_sh[127:96];
                if (port_ack) begin
                    word_d = word_q + 3'd1;
                    if (word_q == 3'd3) begin
                        state_d = ST_WR_NEXT;
                        word_d  = '0;
                    end
                end
            end
            ST_WR_NEXT: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = OFF_CTRL;
                preq.wdata  = 32'h2;
                if (port_ack) state_d = ST_WR_CLR2;
            end
            ST_WR_CLR2: begin
                port_req_c  = 1'b1;
                preq.we     = 1'b1;
                preq.offset = OFF_CTRL;
                if (port_ack) begin
                    state_d = ST_POLL_VLD;
                    poll_d  = '0;
                end
            end
            ST_POLL_VLD: begin
                port_req_c  = 1'b1;
                preq.offset = OFF_STATUS;
                if (port_ack) begin
                    if (port_rdata[1]) begin
                        state_d = ST_RD_RES;
                        word_d  = '0;
                    end else if (poll_q + POLL_W'(1) == POLL_W'(POLL_LIMIT)) begin
                        timeout_c = 1'b1;
                    end else begin
                        poll_d = poll_q + POLL_W'(1);
                    end
                end
            end
            ST_RD_RES: begin
                port_req_c  = 1'b1;
                preq.offset = word_offset(OFF_RESULT0, word_q);
                // First word read (offset 72) ends up in result[127:96] after four shifts.
                if (port_ack) begin
                    result_d = {result[95:0], port_rdata};
                    word_d   = word_q + 3'd1;
                    if (word_q == 3'd3) state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A bad response or poll timeout abandons the run; the transaction is already closed here.
        if ((port_ack && port_err) || timeout_c) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            result_d   = result;
            word_d     = '0;
            poll_d     = '0;
            err_code_d = timeout_c && !port_err ? ERR_TIMEOUT : (preq.we ? ERR_BRESP : ERR_RRESP);
        end
    end

    function automatic logic busy_q_w();
        return busy;
    endfunction

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            poll_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            result   <= '0;
            key_q    <= '0;
            blk_q    <= '0;
            cfg_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            poll_q   <= poll_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            err_code <= err_code_d;
            result   <= result_d;
            key_q    <= key_d;
            blk_q    <= blk_d;
            cfg_q    <= cfg_d;
        end
    end

    axil_master_port #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port (
        .aclk        (m00_axi_aclk),
        .aresetn     (m00_axi_aresetn),
        .req         (port_req_c),
        .we          (preq.we),
        .addr        (BASE_ADDR + ADDR_WIDTH'(preq.offset)),
        .wdata       (preq.wdata),
        .ack         (port_ack),
        .rdata       (port_rdata),
        .resp_err    (port_err),
        .axi_awaddr  (m00_axi_awaddr),
        .axi_awprot  (m00_axi_awprot),
        .axi_awvalid (m00_axi_awvalid),
        .axi_awready (m00_axi_awready),
        .axi_wdata   (m00_axi_wdata),
        .axi_wstrb   (m00_axi_wstrb),
        .axi_wvalid  (m00_axi_wvalid),
        .axi_wready  (m00_axi_wready),
        .axi_bresp   (m00_axi_bresp),
        .axi_bvalid  (m00_axi_bvalid),
        .axi_bready  (m00_axi_bready),
        .axi_araddr  (m00_axi_araddr),
        .axi_arprot  (m00_axi_arprot),
        .axi_arvalid (m00_axi_arvalid),
        .axi_arready (m00_axi_arready),
        .axi_rdata   (m00_axi_rdata),
        .axi_rresp   (m00_axi_rresp),
        .axi_rvalid  (m00_axi_rvalid),
        .axi_rready  (m00_axi_rready)
    );

endmodule

// File: tb/tb_aes_axil_sequencer.sv
// Directed bench for aes_axil_sequencer against a behavioural aes_v1_0 register slave.
module tb_aes_axil_sequencer;

    localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_A  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_A  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_B  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_B  = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, reuse_key = 1'b0, key256 = 1'b0, encdec = 1'b1;
    logic [255:0] key = '0;
    logic [127:0] block_in = '0;
    logic [127:0] result;
    logic         busy, done, error;
    logic [1:0]   err_code;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, wvalid, bready, arvalid, rready, bvalid, rvalid;
    logic         awready = 1'b1, wready = 1'b1, arready = 1'b1;
    logic [1:0]   bresp, rresp;

    int total = 0;
    int bad = 0;

    aes_axil_sequencer #(
        .ADDR_WIDTH(32), .BASE_ADDR(32'h0), .POLL_LIMIT(4)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .start(start), .reuse_key(reuse_key), .key(key), .key256(key256), .encdec(encdec),
        .block_in(block_in), .result(result), .busy(busy), .done(done), .error(error),
        .err_code(err_code),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    // Slave model state
    bit          rand_mode = 0, inject_bresp = 0, stuck = 0;
    logic [31:0] s_key [8];
    logic [31:0] s_blk [4];
    logic [31:0] s_res [4];
    logic [31:0] s_cfg = '0;
    bit          rdy_flag = 0, vld_flag = 0;
    int          rdy_wait = 0, vld_wait = 0;
    int          aw_hs_cnt = 0, status_rd_cnt = 0, viol_cnt = 0, done_cnt = 0;
    logic [31:0] wr_log [$];
    logic        aw_got, w_got, aw_hs, w_hs;
    logic [31:0] aw_lat, w_lat, wa, wd;
    logic        aw_pend, w_pend, ar_pend;

    function automatic void slave_write(input logic [31:0] a, input logic [31:0] d);
        logic [255:0] kc;
        logic [127:0] bc, r;
        if (a == 32'd0) begin
            if (d[0]) begin rdy_flag = 1; rdy_wait = 1; end
            if (d[1]) begin
                vld_flag = 1; vld_wait = 2;
                kc = {s_key[0], s_key[1], s_key[2], s_key[3], s_key[4], s_key[5], s_key[6], s_key[7]};
                bc = {s_blk[0], s_blk[1], s_blk[2], s_blk[3]};
                if (kc == KEY_A && s_cfg == 32'h1)
                    r = (bc == PT_A) ? CT_A : ((bc == PT_B) ? CT_B : 128'hdead0000dead0000dead0000dead0000);
                else
                    r = 128'hbad00000bad00000bad00000bad00000;
                s_res[0] = r[127:96]; s_res[1] = r[95:64]; s_res[2] = r[63:32]; s_res[3] = r[31:0];
            end
        end else if (a == 32'd4) begin
            s_cfg = d;
        end else if (a >= 32'd24 && a <= 32'd52) begin
            s_key[(a - 32'd24) >> 2] = d;
        end else if (a >= 32'd56 && a <= 32'd68) begin
            s_blk[(a - 32'd56) >> 2] = d;
        end
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        logic r0, r1;
        if (a == 32'd8) begin
            status_rd_cnt++;
            r0 = rdy_flag && rdy_wait == 0 && !stuck;
            r1 = vld_flag && vld_wait == 0 && !stuck;
            if (rdy_wait > 0) rdy_wait--;
            if (vld_wait > 0) vld_wait--;
            return {30'h0, r1, r0};
        end else if (a >= 32'd72 && a <= 32'd84) begin
            return s_res[(a - 32'd72) >> 2];
        end
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_lat <= '0; w_lat <= '0;
        end else begin
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (aw_hs) begin aw_got <= 1'b1; aw_lat <= awaddr; aw_hs_cnt++; end
            if (w_hs)  begin w_got <= 1'b1; w_lat <= wdata; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                wa = aw_hs ? awaddr : aw_lat;
                wd = w_hs ? wdata : w_lat;
                aw_got <= 1'b0; w_got <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= (inject_bresp && wa == 32'd4) ? 2'b10 : 2'b00;
                wr_log.push_back(wa);
                slave_write(wa, wd);
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= slave_read(araddr);
            end
        end
    end

    always @(negedge clk) begin
        awready = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        wready  = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        arready = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    // A valid seen waiting for ready must still be high on the next edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid)) viol_cnt++;
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
            ar_pend <= arvalid && !arready;
            if (done) done_cnt++;
        end
    end

    task automatic run_op(input bit reuse, input logic [127:0] blk, output bit finished);
        @(negedge clk);
        start = 1'b1; reuse_key = reuse; block_in = blk; key = KEY_A; key256 = 1'b0; encdec = 1'b1;
        @(negedge clk);
        start = 1'b0; block_in = ~blk; key = ~KEY_A; encdec = 1'b0;
        finished = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || error) begin finished = 1; break; end
            if (i == 10) begin start = 1'b1; reuse_key = ~reuse; end
            else start = 1'b0;
        end
        start = 1'b0;
        total++;
        if (!finished) begin bad++; $display("FAIL run_timeout: got busy=%0b want done or error", busy); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL reset_pulses: got %b%b want 00", done, error); end
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        total++; if (result !== 128'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
            bad++; $display("FAIL reset_handshake: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        total++; if (awaddr !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0) begin
            bad++; $display("FAIL reset_addr_data: got %h %h %h want 0", awaddr, araddr, wdata); end
        total++; if (wstrb !== 4'hF || awprot !== 3'b000 || arprot !== 3'b000) begin
            bad++; $display("FAIL strb_prot: got %h %h %h want f 0 0", wstrb, awprot, arprot); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        logic [31:0] exp_log [17] = '{32'd24, 32'd28, 32'd32, 32'd36, 32'd40, 32'd44, 32'd48, 32'd52,
                                      32'd4, 32'd0, 32'd0, 32'd56, 32'd60, 32'd64, 32'd68, 32'd0, 32'd0};
        int n0 = wr_log.size();
        int d0 = done_cnt;
        int mis = 0;
        bit fin;
        run_op(0, PT_A, fin);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done: got %b want 1", done); end
        total++; if (result !== CT_A) begin bad++; $display("FAIL full_result: got %h want %h", result, CT_A); end
        total++; if (wr_log.size() - n0 != 17) begin bad++; $display("FAIL full_write_count: got %0d want 17", wr_log.size() - n0); end
        for (int i = 0; i < 17 && n0 + i < wr_log.size(); i++)
            if (wr_log[n0 + i] !== exp_log[i]) mis++;
        total++; if (mis != 0) begin bad++; $display("FAIL full_write_order: got %0d wrong addresses want 0", mis); end
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt - d0); end
        total++; if (result !== CT_A || busy !== 1'b0) begin bad++; $display("FAIL full_hold: got %h busy=%b want %h busy=0", result, busy, CT_A); end
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL full_err_code: got %0d want 0", err_code); end
    endtask

    task automatic test_reuse_key();
        int n0 = wr_log.size();
        int hits = 0;
        bit fin;
        run_op(1, PT_B, fin);
        total++; if (result !== CT_B) begin bad++; $display("FAIL reuse_result: got %h want %h", result, CT_B); end
        for (int i = n0; i < wr_log.size(); i++)
            if (wr_log[i] == 32'd4 || (wr_log[i] >= 32'd24 && wr_log[i] <= 32'd52)) hits++;
        total++; if (hits != 0) begin bad++; $display("FAIL reuse_no_key_writes: got %0d want 0", hits); end
        total++; if (wr_log.size() - n0 != 6) begin bad++; $display("FAIL reuse_write_count: got %0d want 6", wr_log.size() - n0); end
    endtask

    task automatic test_bresp_error();
        int a0;
        bit fin;
        inject_bresp = 1;
        run_op(0, PT_A, fin);
        total++; if (error !== 1'b1) begin bad++; $display("FAIL bresp_error_pulse: got %b want 1", error); end
        total++; if (err_code !== 2'd1) begin bad++; $display("FAIL bresp_err_code: got %0d want 1", err_code); end
        total++; if (wr_log[wr_log.size() - 1] !== 32'd4) begin bad++; $display("FAIL bresp_last_write: got %0d want 4", wr_log[wr_log.size() - 1]); end
        a0 = aw_hs_cnt;
        repeat (20) @(negedge clk);
        total++; if (aw_hs_cnt != a0 || awvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bresp_quiet: got aw=%0d awvalid=%b busy=%b want 0 0 0", aw_hs_cnt - a0, awvalid, busy); end
        total++; if (err_code !== 2'd1 || error !== 1'b0) begin bad++; $display("FAIL bresp_hold: got code=%0d error=%b want 1 0", err_code, error); end
        inject_bresp = 0;
    endtask

    task automatic test_poll_timeout();
        int s0 = status_rd_cnt;
        bit fin;
        stuck = 1;
        run_op(0, PT_A, fin);
        total++; if (err_code !== 2'd3 || error !== 1'b1) begin bad++; $display("FAIL timeout_code: got %0d error=%b want 3 1", err_code, error); end
        repeat (5) @(negedge clk);
        total++; if (status_rd_cnt - s0 != 4) begin bad++; $display("FAIL timeout_status_reads: got %0d want 4", status_rd_cnt - s0); end
        stuck = 0;
    endtask

    task automatic test_random_ready();
        int v0 = viol_cnt;
        bit fin;
        rand_mode = 1;
        run_op(0, PT_A, fin);
        total++; if (result !== CT_A || err_code !== 2'd0) begin bad++; $display("FAIL rand_full_result: got %h code=%0d want %h 0", result, err_code, CT_A); end
        run_op(1, PT_B, fin);
        total++; if (result !== CT_B) begin bad++; $display("FAIL rand_reuse_result: got %h want %h", result, CT_B); end
        total++; if (viol_cnt != v0) begin bad++; $display("FAIL rand_valid_stable: got %0d early drops want 0", viol_cnt - v0); end
        rand_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        bit fin;
        @(negedge clk);
        start = 1'b1; reuse_key = 1'b1; block_in = PT_A; key = KEY_A;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (awvalid && awaddr == 32'd56) begin seen = 1; break; end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_reach_wr_blk: got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset_drop: got %b busy=%b want 00000 0", {awvalid, wvalid, arvalid, bready, rready}, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(0, PT_A, fin);
        total++; if (result !== CT_A || done !== 1'b1) begin bad++; $display("FAIL mid_rerun_result: got %h done=%b want %h 1", result, done, CT_A); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_reuse_key();
        test_bresp_error();
        test_poll_timeout();
        test_random_ready();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
